// File: rtl/huff_encoder_tx.sv
// Table-driven Huffman encoder: 256-entry code table, one character in, code bits out MSB first.
// Optional bit statistics counter enabled by defining ENC_STATS_EN.
module huff_encoder_tx (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        tbl_we,
  input  logic [7:0]  tbl_char,
  input  logic [3:0]  tbl_length,
  input  logic [11:0] tbl_path,
  input  logic [7:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  output logic        bit_out,
  output logic        bit_valid,
  input  logic        bit_ready,
  output logic        bit_last,
  output logic        code_err,
  output logic        busy
`ifdef ENC_STATS_EN
  ,
  input  logic        stats_clr,
  output logic [15:0] bit_count
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  logic [15:0] tbl_q [256];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [11:0] path_q, path_d;
  logic        code_err_q, code_err_d;
  logic        char_ready_q, char_ready_d;
  logic        bit_valid_q, bit_valid_d;
  logic        bit_out_q, bit_out_d;
  logic        bit_last_q, bit_last_d;
  logic        busy_q, busy_d;

  logic [15:0] entry;
  logic [3:0]  entry_len;
  logic        entry_mapped;
  logic        bit_hs;
  logic [15:0] path_ext_d;
  logic [3:0]  bit_idx_d;

  // Lookup uses the registered table, so a same-cycle write is seen only afterwards.
  always_comb begin
    entry        = tbl_q[char_in];
    entry_len    = entry[15:12];
    entry_mapped = (entry_len != 4'd0) && (entry_len <= 4'd12);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < 256; i++) tbl_q[i] <= 16'h0000;
    end else if (tbl_we) begin
      tbl_q[tbl_char] <= {tbl_length, tbl_path};
    end
  end

  assign bit_hs = (state_q == SHIFT) && bit_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    path_d     = path_q;
    code_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (char_valid) begin
          if (entry_mapped) begin
            path_d  = entry[11:0];
            cnt_d   = entry_len;
            state_d = SHIFT;
          end else begin
            code_err_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (bit_ready) begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so the first bit appears right after acceptance.
  always_comb begin
    path_ext_d   = {4'b0000, path_d};
    bit_idx_d    = cnt_d - 4'd1;
    char_ready_d = (state_d == IDLE);
    bit_valid_d  = (state_d == SHIFT);
    busy_d       = (state_d == SHIFT);
    bit_out_d    = (state_d == SHIFT) ? path_ext_d[bit_idx_d] : 1'b0;
    bit_last_d   = (state_d == SHIFT) && (cnt_d == 4'd1);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      path_q       <= 12'd0;
      code_err_q   <= 1'b0;
      char_ready_q <= 1'b1;
      bit_valid_q  <= 1'b0;
      bit_out_q    <= 1'b0;
      bit_last_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      path_q       <= path_d;
      code_err_q   <= code_err_d;
      char_ready_q <= char_ready_d;
      bit_valid_q  <= bit_valid_d;
      bit_out_q    <= bit_out_d;
      bit_last_q   <= bit_last_d;
      busy_q       <= busy_d;
    end
  end

  assign char_ready = char_ready_q;
  assign bit_valid  = bit_valid_q;
  assign bit_out    = bit_out_q;
  assign bit_last   = bit_last_q;
  assign code_err   = code_err_q;
  assign busy       = busy_q;

`ifdef ENC_STATS_EN
  logic [15:0] bit_count_q, bit_count_d;

  // Clear wins over a simultaneous handshake; counter sticks at all-ones.
  always_comb begin
    bit_count_d = bit_count_q;
    if (stats_clr) begin
      bit_count_d = 16'd0;
    end else if (bit_hs && (bit_count_q != 16'hFFFF)) begin
      bit_count_d = bit_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) bit_count_q <= 16'd0;
    else        bit_count_q <= bit_count_d;
  end

  assign bit_count = bit_count_q;
`else
  logic unused_hs;
  assign unused_hs = bit_hs;
`endif

endmodule

// File: tb/tb_huff_encoder_tx.sv
// Directed self-checking bench for huff_encoder_tx; stats checks compile in with ENC_STATS_EN.
module tb_huff_encoder_tx;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        tbl_we;
  logic [7:0]  tbl_char;
  logic [3:0]  tbl_length;
  logic [11:0] tbl_path;
  logic [7:0]  char_in;
  logic        char_valid;
  logic        char_ready;
  logic        bit_out;
  logic        bit_valid;
  logic        bit_ready;
  logic        bit_last;
  logic        code_err;
  logic        busy;
`ifdef ENC_STATS_EN
  logic        stats_clr;
  logic [15:0] bit_count;
`endif

  int checks = 0;
  int errors = 0;

  huff_encoder_tx dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .tbl_we     (tbl_we),
    .tbl_char   (tbl_char),
    .tbl_length (tbl_length),
    .tbl_path   (tbl_path),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .bit_last   (bit_last),
    .code_err   (code_err),
    .busy       (busy)
`ifdef ENC_STATS_EN
    ,
    .stats_clr  (stats_clr),
    .bit_count  (bit_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] ch, input logic [3:0] len, input logic [11:0] path);
    tbl_we = 1'b1; tbl_char = ch; tbl_length = len; tbl_path = path;
    tick();
    tbl_we = 1'b0;
  endtask

  // Offers one character and collects its bits; optional stall and in-flight table rewrite.
  task automatic run_code(input logic [7:0] ch, input int len, input int stall_at, input int stall_n,
                          input int wr_at, input logic [15:0] wr_val,
                          output logic [11:0] got, output int nbits, output bit last_ok, output bit stall_ok);
    logic hb, hl;
    bit stalled;
    got = '0; nbits = 0; last_ok = 1'b1; stall_ok = 1'b1; stalled = 1'b0;
    bit_ready = 1'b1; char_in = ch; char_valid = 1'b1;
    tick();
    char_valid = 1'b0;
    for (int cyc = 0; cyc < 64 && nbits < len; cyc++) begin
      if (bit_valid !== 1'b1) break;
      if (nbits == stall_at && !stalled) begin
        stalled = 1'b1; bit_ready = 1'b0; hb = bit_out; hl = bit_last;
        for (int s = 0; s < stall_n; s++) begin
          tick();
          if (bit_out !== hb || bit_last !== hl || bit_valid !== 1'b1) stall_ok = 1'b0;
        end
        bit_ready = 1'b1;
      end
      if (nbits == wr_at) begin
        tbl_we = 1'b1; tbl_char = ch; tbl_length = wr_val[15:12]; tbl_path = wr_val[11:0];
      end
      got = {got[10:0], bit_out};
      if (bit_last !== (nbits == len - 1)) last_ok = 1'b0;
      nbits++;
      tick();
      tbl_we = 1'b0;
    end
  endtask

  task automatic test_reset();
    checks++; if (char_ready !== 1'b1) begin errors++; $display("FAIL reset_char_ready got=%b exp=1", char_ready); end
    checks++; if (bit_valid !== 1'b0) begin errors++; $display("FAIL reset_bit_valid got=%b exp=0", bit_valid); end
    checks++; if (bit_out !== 1'b0) begin errors++; $display("FAIL reset_bit_out got=%b exp=0", bit_out); end
    checks++; if (bit_last !== 1'b0) begin errors++; $display("FAIL reset_bit_last got=%b exp=0", bit_last); end
    checks++; if (code_err !== 1'b0) begin errors++; $display("FAIL reset_code_err got=%b exp=0", code_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
`ifdef ENC_STATS_EN
    checks++; if (bit_count !== 16'd0) begin errors++; $display("FAIL reset_bit_count got=%0d exp=0", bit_count); end
`endif
  endtask

  task automatic test_basic();
    logic [11:0] got; int n; bit lok, sok;
    load(8'h41, 4'd3, 12'b101);
    run_code(8'h41, 3, -1, 0, -1, 16'h0, got, n, lok, sok);
    checks++; if (got !== 12'h005 || n != 3) begin errors++; $display("FAIL basic_bits got=%h/%0d exp=005/3", got, n); end
    checks++; if (!lok) begin errors++; $display("FAIL basic_last got=bad exp=only_third"); end
    checks++; if (char_ready !== 1'b1 || bit_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_idle got=rdy%b val%b busy%b exp=rdy1 val0 busy0", char_ready, bit_valid, busy);
    end
  endtask

  task automatic test_unmapped();
    char_in = 8'h7F; char_valid = 1'b1;
    tick();
    char_valid = 1'b0;
    checks++; if (code_err !== 1'b1) begin errors++; $display("FAIL unmapped_err got=%b exp=1", code_err); end
    checks++; if (bit_valid !== 1'b0 || char_ready !== 1'b1) begin
      errors++; $display("FAIL unmapped_state got=val%b rdy%b exp=val0 rdy1", bit_valid, char_ready);
    end
    tick();
    checks++; if (code_err !== 1'b0) begin errors++; $display("FAIL unmapped_pulse got=%b exp=0", code_err); end
    load(8'h50, 4'd13, 12'hFFF);
    char_in = 8'h50; char_valid = 1'b1;
    tick();
    char_valid = 1'b0;
    checks++; if (code_err !== 1'b1 || bit_valid !== 1'b0) begin
      errors++; $display("FAIL len13_err got=err%b val%b exp=err1 val0", code_err, bit_valid);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [11:0] got; int n; bit lok, sok;
    load(8'h42, 4'd12, 12'hA5C);
    run_code(8'h42, 12, 4, 3, -1, 16'h0, got, n, lok, sok);
    checks++; if (got !== 12'hA5C || n != 12) begin errors++; $display("FAIL bp_bits got=%h/%0d exp=a5c/12", got, n); end
    checks++; if (!sok) begin errors++; $display("FAIL bp_hold got=changed exp=stable"); end
    checks++; if (!lok) begin errors++; $display("FAIL bp_last got=bad exp=only_twelfth"); end
    checks++; if (char_ready !== 1'b1) begin errors++; $display("FAIL bp_idle got=%b exp=1", char_ready); end
  endtask

  task automatic test_update_in_flight();
    logic [11:0] got; int n; bit lok, sok;
    load(8'h43, 4'd4, 12'b1011);
    run_code(8'h43, 4, -1, 0, 1, {4'd2, 12'h000}, got, n, lok, sok);
    checks++; if (got !== 12'h00B || n != 4 || !lok) begin errors++; $display("FAIL inflight_old got=%h/%0d exp=00b/4", got, n); end
    run_code(8'h43, 2, -1, 0, -1, 16'h0, got, n, lok, sok);
    checks++; if (got !== 12'h000 || n != 2 || !lok) begin errors++; $display("FAIL inflight_new got=%h/%0d exp=000/2", got, n); end
    checks++; if (char_ready !== 1'b1) begin errors++; $display("FAIL inflight_idle got=%b exp=1", char_ready); end
  endtask

  task automatic test_same_cycle_write();
    logic [11:0] got; int n; bit lok, sok;
    load(8'h44, 4'd2, 12'b10);
    tbl_we = 1'b1; tbl_char = 8'h44; tbl_length = 4'd3; tbl_path = 12'b111;
    char_in = 8'h44; char_valid = 1'b1; bit_ready = 1'b1;
    tick();
    tbl_we = 1'b0; char_valid = 1'b0;
    checks++; if (bit_out !== 1'b1 || bit_last !== 1'b0) begin errors++; $display("FAIL samecyc_b0 got=%b%b exp=10", bit_out, bit_last); end
    tick();
    checks++; if (bit_out !== 1'b0 || bit_last !== 1'b1) begin errors++; $display("FAIL samecyc_b1 got=%b%b exp=01", bit_out, bit_last); end
    tick();
    checks++; if (char_ready !== 1'b1) begin errors++; $display("FAIL samecyc_idle got=%b exp=1", char_ready); end
    run_code(8'h44, 3, -1, 0, -1, 16'h0, got, n, lok, sok);
    checks++; if (got !== 12'h007 || n != 3) begin errors++; $display("FAIL samecyc_new got=%h/%0d exp=007/3", got, n); end
  endtask

  task automatic test_back_to_back();
    int cnt;
    char_in = 8'h41; char_valid = 1'b1; bit_ready = 1'b1;
    tick();
    cnt = 1;
    while (char_ready !== 1'b1 && cnt < 20) begin tick(); cnt++; end
    checks++; if (cnt != 4) begin errors++; $display("FAIL b2b_period got=%0d exp=4", cnt); end
    tick();
    char_valid = 1'b0;
    checks++; if (bit_valid !== 1'b1 || bit_out !== 1'b1) begin errors++; $display("FAIL b2b_second got=val%b bit%b exp=val1 bit1", bit_valid, bit_out); end
    cnt = 0;
    while (char_ready !== 1'b1 && cnt < 20) begin tick(); cnt++; end
    checks++; if (cnt != 3) begin errors++; $display("FAIL b2b_drain got=%0d exp=3", cnt); end
  endtask

  task automatic test_reset_mid_code();
    load(8'h45, 4'd5, 12'b11010);
    char_in = 8'h45; char_valid = 1'b1; bit_ready = 1'b1;
    tick();
    char_valid = 1'b0;
    tick();
    #2;
    n_rst = 1'b0;
    #1;
    checks++; if (bit_valid !== 1'b0 || busy !== 1'b0 || char_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_ctl got=val%b busy%b rdy%b exp=val0 busy0 rdy1", bit_valid, busy, char_ready);
    end
    checks++; if (bit_out !== 1'b0 || bit_last !== 1'b0 || code_err !== 1'b0) begin
      errors++; $display("FAIL rstmid_out got=bit%b last%b err%b exp=000", bit_out, bit_last, code_err);
    end
    tick();
    tick();
    @(negedge clk);
    n_rst = 1'b1;
    tick();
    checks++; if (bit_valid !== 1'b0) begin errors++; $display("FAIL rstmid_nobits got=%b exp=0", bit_valid); end
    char_in = 8'h45; char_valid = 1'b1;
    tick();
    char_valid = 1'b0;
    checks++; if (code_err !== 1'b1 || bit_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_tbl got=err%b val%b exp=err1 val0", code_err, bit_valid);
    end
    tick();
  endtask

`ifdef ENC_STATS_EN
  task automatic test_stats();
    logic [11:0] got; int n; bit lok, sok;
    checks++; if (bit_count !== 16'd0) begin errors++; $display("FAIL stats_after_rst got=%0d exp=0", bit_count); end
    load(8'h41, 4'd3, 12'b101);
    load(8'h42, 4'd12, 12'hA5C);
    run_code(8'h41, 3, -1, 0, -1, 16'h0, got, n, lok, sok);
    run_code(8'h42, 12, -1, 0, -1, 16'h0, got, n, lok, sok);
    checks++; if (bit_count !== 16'd15) begin errors++; $display("FAIL stats_count got=%0d exp=15", bit_count); end
    char_in = 8'h41; char_valid = 1'b1; bit_ready = 1'b1;
    tick();
    char_valid = 1'b0; stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    checks++; if (bit_count !== 16'd0) begin errors++; $display("FAIL stats_clr got=%0d exp=0", bit_count); end
    tick();
    tick();
    checks++; if (bit_count !== 16'd2) begin errors++; $display("FAIL stats_resume got=%0d exp=2", bit_count); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_rst = 1'b0; tbl_we = 1'b0; tbl_char = '0; tbl_length = '0; tbl_path = '0;
    char_in = '0; char_valid = 1'b0; bit_ready = 1'b0;
`ifdef ENC_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    tick();
    test_reset();
    test_basic();
    test_unmapped();
    test_backpressure();
    test_update_in_flight();
    test_same_cycle_write();
    test_back_to_back();
    test_reset_mid_code();
`ifdef ENC_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/huff_encoder_tx.md
HUFF_ENCODER_TX -- requirements
Module: huff_encoder_tx

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports listed first:
- clk  in  1  rising-edge clock
- n_rst  in  1  async active-low reset
REQ-002 The code-table load ports SHALL be:
- tbl_we  in  1  write strobe
- tbl_char  in  8  table entry index (character)
- tbl_length  in  4  code length
- tbl_path  in  12  code bits, right-aligned
REQ-003 The character input ports SHALL be:
- char_in  in  8  character to encode
- char_valid  in  1  character offered
- char_ready  out  1  block can accept a character
REQ-004 The serial bit output ports SHALL be:
- bit_out  out  1  current code bit
- bit_valid  out  1  bit_out is valid
- bit_ready  in  1  sink accepts bit_out
- bit_last  out  1  bit_out is the final bit of the code
REQ-005 The status ports SHALL be:
- code_err  out  1  one-cycle pulse: unmapped character
- busy  out  1  shifting in progress
REQ-006 When ENC_STATS_EN is defined, the block SHALL add:
- stats_clr  in  1  synchronous clear
- bit_count  out  16  total bits emitted

Function
REQ-007 The block SHALL hold a 256-entry table of {length[3:0], path[11:0]}, written on any cycle with tbl_we=1 at index tbl_char.
REQ-008 A table entry with length 0 or length >12 SHALL be treated as unmapped.
REQ-009 The FSM SHALL have exactly two states:
- IDLE: char_ready=1
- SHIFT: char_ready=0
REQ-010 In IDLE, char_valid=1 SHALL accept char_in and read its entry in the same cycle.
- Mapped entry: latch path, load bit counter cnt=length, move to SHIFT.
- Unmapped entry: pulse code_err high for the next cycle and remain in IDLE.
REQ-011 In SHIFT, the outputs SHALL be bit_valid=1, bit_out=path[cnt-1] (MSB of the code first), busy=1, and bit_last=(cnt==1).
REQ-012 In SHIFT, a cycle with bit_valid&bit_ready SHALL decrement cnt.
- On the bit_last handshake, the next state SHALL be IDLE.
- No bubble: the first bit SHALL appear the cycle after acceptance.
REQ-013 With bit_ready=0, bit_out, bit_last and cnt SHALL hold stable.
REQ-014 A table write to the character currently being shifted SHALL NOT alter the code in flight.
REQ-015 A table write and an acceptance of the same index in the same cycle SHALL use the pre-write entry.
REQ-016 An unloaded entry is unmapped, so accepting an unloaded character SHALL give code_err.
REQ-017 Throughput SHALL be one code of length L per L+1 cycles, with bit_ready held high.

Reset
REQ-018 n_rst=0 SHALL asynchronously force the following, regardless of state (including mid-SHIFT):
- state=IDLE, cnt=0, latched path=0
- all table entries = {0,0}
- char_ready=1, bit_valid=0, bit_out=0, bit_last=0, code_err=0, busy=0, bit_count=0
REQ-019 A code interrupted by reset SHALL be abandoned, and no further bits of it SHALL be emitted.

Configuration
REQ-020 The macro ENC_STATS_EN SHALL control the statistics counter.
- Defined: bit_count increments on each bit handshake and saturates at 16'hFFFF.
- Defined: stats_clr=1 zeroes bit_count and has priority over a simultaneous increment.
- Not defined: the stats_clr and bit_count ports and their logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-021 Basic encode: load 'A'(8'h41)={3,3'b101}, offer 'A', bit_ready=1 -> bits 1,0,1 on 3 consecutive cycles; bit_last only on the third; char_ready back the next cycle.
REQ-022 Unmapped character: offer 8'h7F with no table entry -> code_err high for exactly 1 cycle, bit_valid stays 0, char_ready stays 1.
REQ-023 Backpressure: load 12-bit code 12'hA5C, drop bit_ready for 3 cycles mid-code -> output held stable; the full sequence 1010_0101_1100 is emitted in order.
REQ-024 Table update in flight: rewrite the in-flight character to {2,2'b00} during SHIFT -> current code unchanged; the next encode of it emits 0,0.
REQ-025 Reset mid-code: assert n_rst during the 2nd bit of a 5-bit code -> all outputs reach reset values immediately; after release the table is empty (re-offering gives code_err).
REQ-026 Statistics (ENC_STATS_EN defined): encode codes of 3+12 bits -> bit_count=15; pulse stats_clr together with a bit handshake -> bit_count=0.
